// File: rtl/card_pkg.sv
// Shared types and constants for the card shoe.
//   rank_t / suit_t  : card encoding seen by the baccarat datapath
//   shoe_state_t     : dealer FSM states
//   card_bit()       : (suit, rank) -> position in the 52-bit used mask
package card_pkg;

  localparam int RANK_MAX  = 13;
  localparam int DECK_SIZE = 4 * RANK_MAX;

  typedef logic [3:0] rank_t;
  typedef logic [1:0] suit_t;

  typedef enum logic {IDLE, SEARCH} shoe_state_t;

  // Ranks are 1-based, so rank 0 never reaches this function.
  function automatic logic [5:0] card_bit(suit_t s, rank_t r);
    return ({4'b0000, s} * 6'(RANK_MAX)) + {2'b00, r} - 6'd1;
  endfunction

endpackage

// File: rtl/card_index_counter.sv
// Suit/rank wrap counter: rank 1..RANK_MAX, carry into a 2-bit suit that
// wraps 3 -> 0. Resets to suit 0 rank 1. Load has priority over enable.
//   clock, resetb          : clock, async active-low reset
//   load_i, load_suit_i/_rank_i : synchronous load of a position
//   en_i                   : advance one position
//   suit_o, rank_o         : current position
module card_index_counter
  import card_pkg::*;
#(
  parameter int RANK_MAX = card_pkg::RANK_MAX
) (
  input  logic  clock,
  input  logic  resetb,
  input  logic  load_i,
  input  suit_t load_suit_i,
  input  rank_t load_rank_i,
  input  logic  en_i,
  output suit_t suit_o,
  output rank_t rank_o
);

  suit_t suit_q, suit_d;
  rank_t rank_q, rank_d;

  always_comb begin
    suit_d = suit_q;
    rank_d = rank_q;
    if (load_i) begin
      suit_d = load_suit_i;
      rank_d = load_rank_i;
    end else if (en_i) begin
      if (rank_q == rank_t'(RANK_MAX)) begin
        rank_d = rank_t'(1);
        suit_d = suit_q + suit_t'(1);
      end else begin
        rank_d = rank_q + rank_t'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      suit_q <= '0;
      rank_q <= rank_t'(1);
    end else begin
      suit_q <= suit_d;
      rank_q <= rank_d;
    end
  end

  assign suit_o = suit_q;
  assign rank_o = rank_q;

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe dealing without replacement. A request latches the current
// value of a free-running index counter as a probe pointer; the probe then
// walks forward past already-dealt cards until it finds a free one.
//   clock, resetb  : fast clock, async active-low reset
//   req, shuffle   : deal request / return all cards (shuffle wins)
//   card_valid     : one-cycle pulse, new card on rank/suit
//   rank, suit     : last dealt card (rank 0 = none since reset/shuffle)
//   cards_left     : undealt cards, empty when zero
//   underflow      : one-cycle pulse, request accepted while empty
//
// state  | meaning
// IDLE   | waiting for req/shuffle
// SEARCH | probing the used mask for a free card
module card_shoe
  import card_pkg::*;
#(
  parameter int DECK_SIZE = card_pkg::DECK_SIZE,
  parameter int RANK_MAX  = card_pkg::RANK_MAX
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       req,
  input  logic       shuffle,
  output logic       card_valid,
  output logic [3:0] rank,
  output logic [1:0] suit,
  output logic [5:0] cards_left,
  output logic       empty,
  output logic       underflow
);

  shoe_state_t          state_q, state_d;
  logic [DECK_SIZE-1:0] mask_q, mask_d;
  logic [5:0]           left_q, left_d;
  rank_t                rank_q, rank_d;
  suit_t                suit_q, suit_d;
  logic                 valid_q, valid_d;
  logic                 uflow_q, uflow_d;

  suit_t ix_suit, pr_suit;
  rank_t ix_rank, pr_rank;
  logic  pr_load, pr_en;
  logic [5:0] pr_bit;

  card_index_counter #(.RANK_MAX(RANK_MAX)) u_index (
    .clock(clock), .resetb(resetb),
    .load_i(1'b0), .load_suit_i('0), .load_rank_i('0), .en_i(1'b1),
    .suit_o(ix_suit), .rank_o(ix_rank)
  );

  // Probe pointer starts from the pre-increment index value on accept.
  card_index_counter #(.RANK_MAX(RANK_MAX)) u_probe (
    .clock(clock), .resetb(resetb),
    .load_i(pr_load), .load_suit_i(ix_suit), .load_rank_i(ix_rank), .en_i(pr_en),
    .suit_o(pr_suit), .rank_o(pr_rank)
  );

  assign pr_bit = card_bit(pr_suit, pr_rank);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    left_d  = left_q;
    rank_d  = rank_q;
    suit_d  = suit_q;
    valid_d = 1'b0;
    uflow_d = 1'b0;
    pr_load = 1'b0;
    pr_en   = 1'b0;
    if (shuffle) begin
      // Shuffle wins in either state and aborts any search in flight.
      state_d = IDLE;
      mask_d  = '0;
      left_d  = 6'(DECK_SIZE);
      rank_d  = '0;
      suit_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (left_q == '0) begin
              uflow_d = 1'b1;
            end else begin
              pr_load = 1'b1;
              state_d = SEARCH;
            end
          end
        end
        SEARCH: begin
          if (!mask_q[pr_bit]) begin
            mask_d[pr_bit] = 1'b1;
            rank_d  = pr_rank;
            suit_d  = pr_suit;
            left_d  = left_q - 6'd1;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            pr_en = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      mask_q  <= '0;
      left_q  <= 6'(DECK_SIZE);
      rank_q  <= '0;
      suit_q  <= '0;
      valid_q <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      left_q  <= left_d;
      rank_q  <= rank_d;
      suit_q  <= suit_d;
      valid_q <= valid_d;
      uflow_q <= uflow_d;
    end
  end

  assign card_valid = valid_q;
  assign rank       = rank_q;
  assign suit       = suit_q;
  assign cards_left = left_q;
  assign empty      = (left_q == '0);
  assign underflow  = uflow_q;

endmodule
